// File: rtl/usb_tx_serializer.sv
// Parallel-load USB packet serializer: SYNC, PID, optional DATA+CRC16, then EOP (SE0, SE0, J).
// Bits leave LSB-first as NRZ, one per shift_strobe, ahead of the bit stuffer / NRZI encoder.
module usb_tx_serializer #(
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic                 tx_has_data,
  input  logic [7:0]           tx_pid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [15:0]          tx_crc16,
  input  logic                 shift_strobe,
  output logic                 tx_bit,
  output logic                 tx_se0,
  output logic                 tx_active,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int SH_W  = (DATA_BITS > 16) ? DATA_BITS : 16;
  localparam int CNT_W = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC, EOP1, EOP2, EOPJ
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [SH_W-1:0]      r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_load;

  logic                 r_has_data;
  logic [7:0]           r_pid;
  logic [DATA_BITS-1:0] r_data;
  logic [15:0]          r_crc;

  // Index of the final bit of the field currently being shifted.
  function automatic logic [CNT_W-1:0] last_idx(input state_t s);
    case (s)
      DATA:    return CNT_W'(DATA_BITS - 1);
      CRC:     return CNT_W'(15);
      default: return CNT_W'(7);
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Packet fields are captured once at start so later input changes cannot corrupt the stream.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_has_data <= tx_has_data;
      r_pid      <= tx_pid;
      r_data     <= tx_data;
      r_crc      <= tx_crc16;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_load        = 1'b1;
          w_state_nxt   = SYNC;
          w_shreg_nxt   = SH_W'(8'h80);
          w_bit_cnt_nxt = '0;
        end
      end
      SYNC, PID, DATA, CRC: begin
        if (shift_strobe) begin
          if (r_bit_cnt == last_idx(r_state)) begin
            w_bit_cnt_nxt = '0;
            case (r_state)
              SYNC: begin
                w_state_nxt = PID;
                w_shreg_nxt = SH_W'(r_pid);
              end
              PID: begin
                if (r_has_data) begin
                  w_state_nxt = DATA;
                  w_shreg_nxt = SH_W'(r_data);
                end else begin
                  w_state_nxt = EOP1;
                  w_shreg_nxt = '0;
                end
              end
              DATA: begin
                w_state_nxt = CRC;
                w_shreg_nxt = SH_W'(r_crc);
              end
              default: begin
                w_state_nxt = EOP1;
                w_shreg_nxt = '0;
              end
            endcase
          end else begin
            w_shreg_nxt   = r_shreg >> 1;
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      EOP1: if (shift_strobe) w_state_nxt = EOP2;
      EOP2: if (shift_strobe) w_state_nxt = EOPJ;
      EOPJ: begin
        if (shift_strobe) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    tx_se0 = 1'b0;
    case (r_state)
      SYNC, PID, DATA, CRC: tx_bit = r_shreg[0];
      EOP1, EOP2: begin
        tx_bit = 1'b0;
        tx_se0 = 1'b1;
      end
      default: tx_bit = 1'b1;
    endcase
  end

  assign tx_active = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign tx_done   = r_done;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: expected line symbols are queued when a packet is
// started and popped whenever the serializer consumes a bit on shift_strobe.
module tb_usb_tx_serializer;
  localparam int DATA_BITS = 64;
  localparam int BUDGET    = 4000;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 tx_start;
  logic                 tx_has_data;
  logic [7:0]           tx_pid;
  logic [DATA_BITS-1:0] tx_data;
  logic [15:0]          tx_crc16;
  logic                 shift_strobe;
  logic                 tx_bit;
  logic                 tx_se0;
  logic                 tx_active;
  logic                 busy;
  logic                 tx_done;

  usb_tx_serializer #(.DATA_BITS(DATA_BITS)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .tx_has_data  (tx_has_data),
    .tx_pid       (tx_pid),
    .tx_data      (tx_data),
    .tx_crc16     (tx_crc16),
    .shift_strobe (shift_strobe),
    .tx_bit       (tx_bit),
    .tx_se0       (tx_se0),
    .tx_active    (tx_active),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  // Entry = {last, se0, bit}
  logic [2:0] q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   stb_ctr = 0;
  logic m_active = 1'b0;
  logic m_done = 1'b0;
  logic hold_valid = 1'b0;
  logic [1:0] held = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input logic hd, input logic [7:0] pid,
                          input logic [DATA_BITS-1:0] d, input logic [15:0] crc);
    logic [7:0] sync;
    sync = 8'h80;
    for (int i = 0; i < 8; i++) q.push_back({2'b00, sync[i]});
    for (int i = 0; i < 8; i++) q.push_back({2'b00, pid[i]});
    if (hd) begin
      for (int i = 0; i < DATA_BITS; i++) q.push_back({2'b00, d[i]});
      for (int i = 0; i < 16; i++) q.push_back({2'b00, crc[i]});
    end
    q.push_back(3'b010);
    q.push_back(3'b010);
    q.push_back(3'b101);
  endtask

  // Runs at the falling edge: checks outputs, then advances the model across the next rising edge.
  task automatic monitor();
    logic [2:0] e;
    logic nd;
    nd = 1'b0;
    if (!n_rst) begin
      m_active   = 1'b0;
      m_done     = 1'b0;
      hold_valid = 1'b0;
      q.delete();
    end
    chk("tx_active", tx_active, m_active);
    chk("busy", busy, m_active);
    chk("tx_done", tx_done, m_done);
    if (!m_active) begin
      chk("idle_bit", tx_bit, 1'b1);
      chk("idle_se0", tx_se0, 1'b0);
    end
    if (m_active && hold_valid) chk("hold", {tx_se0, tx_bit}, held);
    if (!n_rst) begin
      hold_valid = 1'b0;
    end else if (!m_active) begin
      if (tx_start) m_active = 1'b1;
      hold_valid = 1'b0;
    end else if (shift_strobe) begin
      hold_valid = 1'b0;
      if (q.size() == 0) begin
        chk("underflow", m_active, 1'b0);
      end else begin
        e = q.pop_front();
        n_pop++;
        chk("line", {tx_se0, tx_bit}, e[1:0]);
        if (e[2]) begin
          m_active = 1'b0;
          nd = 1'b1;
          chk("queue_empty", q.size(), 0);
        end
      end
    end else begin
      hold_valid = 1'b1;
      held = {tx_se0, tx_bit};
    end
    m_done = nd;
  endtask

  task automatic cyc(input logic stb);
    shift_strobe = stb;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic cyc_mode(input int mode);
    logic s;
    case (mode)
      0: s = 1'b1;
      1: s = ($urandom_range(0, 3) == 0);
      default: begin
        s = ((stb_ctr % 7) != 6);
        stb_ctr++;
      end
    endcase
    cyc(s);
  endtask

  task automatic send(input logic hd, input logic [7:0] pid, input logic [DATA_BITS-1:0] d,
                      input logic [15:0] crc, input logic stb_on_start);
    tx_has_data = hd;
    tx_pid      = pid;
    tx_data     = d;
    tx_crc16    = crc;
    tx_start    = 1'b1;
    push_pkt(hd, pid, d, crc);
    n_pop = 0;
    cyc(stb_on_start);
  endtask

  task automatic run_done(input int mode, input int exp_len);
    int n;
    n = 0;
    while (!m_done && n < BUDGET) begin
      cyc_mode(mode);
      n++;
    end
    if (n >= BUDGET) chk("timeout", m_done, 1'b1);
    chk("length", n_pop, exp_len);
    cyc(1'b0);
  endtask

  initial begin
    n_rst        = 1'b0;
    tx_start     = 1'b0;
    tx_has_data  = 1'b0;
    tx_pid       = 8'h00;
    tx_data      = '0;
    tx_crc16     = 16'h0000;
    shift_strobe = 1'b0;
    #2;
    cyc(1'b0);
    cyc(1'b1);
    n_rst = 1'b1;
    cyc(1'b0);

    // Handshake, strobe every cycle
    send(1'b0, 8'hD2, '0, 16'h0000, 1'b0);
    run_done(0, 19);

    // Data packet, strobe every cycle
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    run_done(0, 99);

    // Data packet, random quarter-rate strobe
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    run_done(1, 99);

    // Data packet, periodic one-cycle stuff holds
    stb_ctr = 0;
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    run_done(2, 99);

    // Start request mid-DATA is ignored; fields stay latched
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1);
    tx_pid      = 8'h4B;
    tx_has_data = 1'b0;
    tx_data     = 64'hFFFF_0000_FFFF_0000;
    tx_crc16    = 16'h1234;
    tx_start    = 1'b1;
    cyc(1'b1);
    run_done(0, 99);
    send(1'b0, 8'h4B, '0, 16'h0000, 1'b0);
    run_done(0, 19);

    // Reset while DATA bit 40 is on the line
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    for (int i = 0; i < 56; i++) cyc(1'b1);
    n_rst = 1'b0;
    cyc(1'b1);
    chk("rst_bit", tx_bit, 1'b1);
    chk("rst_se0", tx_se0, 1'b0);
    n_rst = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    send(1'b1, 8'hC3, 64'h0123456789ABCDEF, 16'hA5F0, 1'b0);
    run_done(0, 99);

    // Strobe coincident with start in IDLE is not a bit time
    send(1'b0, 8'hD2, '0, 16'h0000, 1'b1);
    run_done(0, 19);
    cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
